// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// MULT/MULTU and DIV/DIVU capture their operands on acceptance, stay busy for a
// fixed number of cycles, then write HI/LO and pulse done. MTHI/MTLO write the
// registers directly at the acceptance edge. Reserved opcodes are ignored.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULRUN = 2'd1,
    DIVRUN = 2'd2
  } state_t;

  state_t      state, nextState;
  logic [4:0]  cnt, cntNext;
  logic [31:0] aR, aNext;
  logic [31:0] bR, bNext;
  logic        signedR, signedNext;
  logic [31:0] hiR, hiNext;
  logic [31:0] loR, loNext;
  logic        busyR, busyNext;
  logic        doneR, doneNext;

  // Datapath results, computed from the captured operands only
  logic        aNeg, bNeg;
  logic [63:0] aExt, bExt, product;
  logic [31:0] aMag, bMag, divisor, qMag, rMag, quot, rem;

  // Multiply via sign/zero extension to 64 bits; divide via magnitudes so the
  // 0x80000000 / -1 case wraps to 0x80000000 with zero remainder.
  always_comb begin
    aNeg    = signedR & aR[31];
    bNeg    = signedR & bR[31];
    aExt    = {{32{aNeg}}, aR};
    bExt    = {{32{bNeg}}, bR};
    product = aExt * bExt;
    aMag    = aNeg ? (~aR + 32'd1) : aR;
    bMag    = bNeg ? (~bR + 32'd1) : bR;
    // A zero divisor never commits a result; substitute 1 to keep the divider defined.
    divisor = (bMag == 32'd0) ? 32'd1 : bMag;
    qMag    = aMag / divisor;
    rMag    = aMag % divisor;
    quot    = (aNeg ^ bNeg) ? (~qMag + 32'd1) : qMag;
    rem     = aNeg ? (~rMag + 32'd1) : rMag;
  end

  // Next-state logic: acceptance, countdown and HI/LO commit
  always_comb begin
    nextState  = state;
    cntNext    = cnt;
    aNext      = aR;
    bNext      = bR;
    signedNext = signedR;
    hiNext     = hiR;
    loNext     = loR;
    doneNext   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              nextState  = MULRUN;
              cntNext    = MULT_N;
              aNext      = a;
              bNext      = b;
              signedNext = (op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              nextState  = DIVRUN;
              cntNext    = DIV_N;
              aNext      = a;
              bNext      = b;
              signedNext = (op == OP_DIV);
            end
            OP_MTHI: hiNext = a;
            OP_MTLO: loNext = a;
            default: nextState = IDLE;
          endcase
        end else begin
          nextState = IDLE;
        end
      end
      MULRUN, DIVRUN: begin
        // start is ignored here; only the countdown advances
        cntNext = cnt - 5'd1;
        if (cnt == 5'd1) begin
          nextState = IDLE;
          doneNext  = 1'b1;
          if (state == MULRUN) begin
            hiNext = product[63:32];
            loNext = product[31:0];
          end else if (bR != 32'd0) begin
            hiNext = rem;
            loNext = quot;
          end else begin
            hiNext = hiR;
            loNext = loR;
          end
        end else begin
          nextState = state;
        end
      end
      default: begin
        nextState = IDLE;
        cntNext   = 5'd0;
      end
    endcase
    busyNext = (cntNext != 5'd0);
  end

  // State and output registers; synchronous reset aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      aR      <= 32'd0;
      bR      <= 32'd0;
      signedR <= 1'b0;
      hiR     <= 32'd0;
      loR     <= 32'd0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
    end else begin
      state   <= nextState;
      cnt     <= cntNext;
      aR      <= aNext;
      bR      <= bNext;
      signedR <= signedNext;
      hiR     <= hiNext;
      loR     <= loNext;
      busyR   <= busyNext;
      doneR   <= doneNext;
    end
  end

  assign busy = busyR;
  assign done = doneR;
  assign hi   = hiR;
  assign lo   = loR;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration in cycles for MULT/MULTU; legal range 1..31.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration in cycles for DIV/DIVU; legal range 1..31.
REQ-003 clk  in  1  clock; all state changes occur on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request strobe, sampled each rising edge.
REQ-006 op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved.
REQ-007 a  in  32  operand A (rs register data).
REQ-008 b  in  32  operand B (rt register data).
REQ-009 busy  out  1  a multiply or divide is in progress.
REQ-010 done  out  1  one-cycle pulse: HI/LO were just updated by a multiply or divide.
REQ-011 hi  out  32  HI register, driven directly from a flop.
REQ-012 lo  out  32  LO register, driven directly from a flop.

Function
REQ-013 An operation SHALL be accepted only when start=1 and busy=0 at a rising edge; a start while busy=1 SHALL be ignored with no state change.
REQ-014 On acceptance, a and b SHALL be captured; later changes on a and b SHALL have no effect on the result.
REQ-015 Accepted MULT/MULTU SHALL set busy=1 for exactly MULT_CYCLES cycles, starting the cycle after acceptance; DIV/DIVU SHALL do the same for exactly DIV_CYCLES cycles.
REQ-016 The internal counter SHALL load N on acceptance and decrement each cycle; busy SHALL equal (counter != 0).
REQ-017 At the edge where the counter goes from 1 to 0, hi/lo SHALL update; busy=0 and done=1 SHALL hold in the following cycle, with done lasting one cycle.
REQ-018 A new start MAY be accepted in the same cycle in which done=1.
REQ-019 MULT SHALL compute the signed 32x32 to 64-bit product; MULTU the unsigned product; hi = product[63:32], lo = product[31:0].
REQ-020 DIV/DIVU SHALL compute lo = quotient and hi = remainder; signed division truncates toward zero and the remainder takes the sign of a.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-022 Division by zero SHALL run the full DIV_CYCLES with busy set; hi and lo SHALL remain unchanged, and done SHALL still pulse.
REQ-023 Accepted MTHI SHALL write hi<=a at the acceptance edge; MTLO SHALL write lo<=a. Neither SHALL assert busy or done.
REQ-024 start with op 6 or 7 SHALL be ignored.
REQ-025 hi and lo SHALL be readable at all times; while busy=1 they SHALL hold their pre-operation values.

Reset
REQ-026 While rst=1 at a rising edge: hi=0, lo=0, busy=0, done=0, and the counter is cleared.
REQ-027 rst SHALL take priority over start; an in-flight operation SHALL be aborted and its result discarded.
REQ-028 Operation SHALL resume normally on the first edge after rst deasserts.

Verification
REQ-029 MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, with a 1-cycle done pulse.
REQ-030 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> busy high for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-032 DIVU b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> 10 busy cycles, done pulses, hi=0x11 and lo=0x22 unchanged.
REQ-033 Issue MULT, then pulse start with op=MTHI on busy cycle 2 -> the MTHI is ignored and hi equals the product high word. Also: a back-to-back start in the done cycle is accepted.
REQ-034 Assert rst on busy cycle 3 of a DIV -> the next cycle shows hi=lo=0, busy=0, and done never pulses.
